// File: rtl/w_update_sched_pkg.sv
// Shared types for the weight-update scheduler and its helpers.
//   sched_state_e : scheduler mode (arbitrating vs. bulk-clear sweep)
//   req_sel_e     : which requester a round-robin pointer favours
//   w_code_t      : 2-bit FIR weight code
package w_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sched_state_e;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_ADP  = 1'b1
  } req_sel_e;

  typedef logic [1:0] w_code_t;

endpackage

// File: rtl/w_update_sched_if.sv
// Bundle of all request, clear-control and FIR-update signals of w_update_sched.
//   master : requester / controller side (drives requests and clr_start)
//   slave  : scheduler side (drives readies, status and the FIR update bus)
interface w_update_sched_if
  import w_ctrl_pkg::*;
#(
  parameter int IDX_W  = 10,
  parameter int DROP_W = 8
);

  logic              host_valid;
  logic [IDX_W-1:0]  host_idx;
  w_code_t           host_data;
  logic              host_ready;

  logic              adp_valid;
  logic [IDX_W-1:0]  adp_idx;
  w_code_t           adp_data;
  logic              adp_ready;

  logic              clr_start;
  w_code_t           clr_value;
  logic              busy;
  logic              clr_done;

  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  w_code_t           upd_data;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output host_valid, host_idx, host_data,
    output adp_valid, adp_idx, adp_data,
    output clr_start, clr_value,
    input  host_ready, adp_ready, busy, clr_done,
    input  upd_valid, upd_idx, upd_data, drop_cnt
  );

  modport slave (
    input  host_valid, host_idx, host_data,
    input  adp_valid, adp_idx, adp_data,
    input  clr_start, clr_value,
    output host_ready, adp_ready, busy, clr_done,
    output upd_valid, upd_idx, upd_data, drop_cnt
  );

endinterface

// File: rtl/w_update_sched_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset (pointer -> requester 0)
//   en       : arbitration enable; no grant when low
//   req[1:0] : request vector (bit 0 = host, bit 1 = adaptive engine)
//   gnt[1:0] : one-hot (or zero) combinational grant
// A lone requester is granted without touching the pointer; on a two-way
// contention the pointed-to side wins and the pointer flips to the other.
module rr_arb2
  import w_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_sel_e ptr;
  logic     contend;

  assign contend = en && (req == 2'b11);

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (ptr == REQ_HOST) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= REQ_HOST;
    end else if (contend) begin
      ptr <= (ptr == REQ_HOST) ? REQ_ADP : REQ_HOST;
    end
  end

endmodule

// File: rtl/w_update_sched.sv
// Write scheduler in front of the FIR weight-bank update port.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : host and adaptive write requests with combinational
//                  readies, bulk-clear start/value with busy/clr_done status,
//                  registered FIR update bus (upd_valid/upd_idx/upd_data) and
//                  the saturating out-of-range drop counter.
// In IDLE the two requesters are round-robin arbitrated; an accepted request
// appears on the update bus one cycle later, or is counted as a drop when its
// index is outside the tap range. In CLEAR every tap index 0..N-1 is written
// with the captured clear value on consecutive cycles.
module w_update_sched
  import w_ctrl_pkg::*;
#(
  parameter int N      = 1008,
  parameter int DROP_W = 8
)(
  input  logic         clock,
  input  logic         reset,
  w_update_sched_if.slave bus
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  sched_state_e      state, state_n;
  logic              upd_valid_q, upd_valid_n;
  logic [IDX_W-1:0]  upd_idx_q, upd_idx_n;
  w_code_t           upd_data_q, upd_data_n;
  logic              clr_done_q, clr_done_n;
  w_code_t           clr_val_q, clr_val_n;
  logic [DROP_W-1:0] drop_q, drop_n;

  logic              arb_en;
  logic [1:0]        gnt;
  logic [IDX_W-1:0]  sel_idx;
  w_code_t           sel_data;

  // A clear start wins over both requesters in the cycle it is seen.
  assign arb_en = (state == IDLE) && !bus.clr_start;

  rr_arb2 u_arb (
    .clk (clock),
    .rst (reset),
    .en  (arb_en),
    .req ({bus.adp_valid, bus.host_valid}),
    .gnt (gnt)
  );

  assign bus.host_ready = gnt[0];
  assign bus.adp_ready  = gnt[1];
  assign bus.busy       = (state == CLEAR);
  assign bus.clr_done   = clr_done_q;
  assign bus.upd_valid  = upd_valid_q;
  assign bus.upd_idx    = upd_idx_q;
  assign bus.upd_data   = upd_data_q;
  assign bus.drop_cnt   = drop_q;

  always_comb begin
    state_n     = state;
    upd_valid_n = 1'b0;
    upd_idx_n   = upd_idx_q;
    upd_data_n  = upd_data_q;
    clr_done_n  = 1'b0;
    clr_val_n   = clr_val_q;
    drop_n      = drop_q;
    sel_idx     = gnt[1] ? bus.adp_idx  : bus.host_idx;
    sel_data    = gnt[1] ? bus.adp_data : bus.host_data;

    unique case (state)
      IDLE: begin
        if (bus.clr_start) begin
          // First sweep write is issued straight from the start cycle.
          state_n     = CLEAR;
          clr_val_n   = bus.clr_value;
          upd_valid_n = 1'b1;
          upd_idx_n   = '0;
          upd_data_n  = bus.clr_value;
          clr_done_n  = (N == 1);
        end else if (gnt != 2'b00) begin
          if (sel_idx > LAST_IDX) begin
            if (drop_q != '1) begin
              drop_n = drop_q + DROP_W'(1);
            end
          end else begin
            upd_valid_n = 1'b1;
            upd_idx_n   = sel_idx;
            upd_data_n  = sel_data;
          end
        end
      end
      CLEAR: begin
        // upd_idx_q is the index currently on the bus; the sweep ends once
        // the last index has been presented.
        if (upd_idx_q == LAST_IDX) begin
          state_n = IDLE;
        end else begin
          upd_valid_n = 1'b1;
          upd_idx_n   = upd_idx_q + IDX_W'(1);
          upd_data_n  = clr_val_q;
          clr_done_n  = ((upd_idx_q + IDX_W'(1)) == LAST_IDX);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_data_q  <= '0;
      clr_done_q  <= 1'b0;
      clr_val_q   <= '0;
      drop_q      <= '0;
    end else begin
      state       <= state_n;
      upd_valid_q <= upd_valid_n;
      upd_idx_q   <= upd_idx_n;
      upd_data_q  <= upd_data_n;
      clr_done_q  <= clr_done_n;
      clr_val_q   <= clr_val_n;
      drop_q      <= drop_n;
    end
  end

endmodule

// File: tb/tb_w_update_sched.sv
// Self-checking bench for w_update_sched: randomized and directed stimulus,
// expected FIR writes pushed to a scoreboard queue by a behavioural model and
// popped/compared by an independent monitor.
module tb_w_update_sched;

  localparam int N      = 1008;
  localparam int IDX_W  = 10;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  typedef struct {
    int cyc;
    int idx;
    int data;
    bit done;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  exp_t sbq[$];

  // model state
  bit ptr_host   = 1'b1;
  int exp_drop   = 0;
  int busy_from  = 1;
  int busy_until = -1;

  w_update_sched_if #(.IDX_W(IDX_W), .DROP_W(DROP_W)) bus ();

  w_update_sched #(.N(N), .DROP_W(DROP_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented write must be the next scoreboard entry, in the
  // exact cycle predicted.
  always @(negedge clock) begin
    if (mon_en) begin
      if (bus.upd_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got idx=%0d data=%0d at cycle %0d, want no write",
                   bus.upd_idx, bus.upd_data, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          tests++;
          if (e.cyc != cyc || int'(bus.upd_idx) != e.idx ||
              int'(bus.upd_data) != e.data || bus.clr_done != e.done) begin
            fails++;
            $display("FAIL write: got cyc=%0d idx=%0d data=%0d done=%0b, want cyc=%0d idx=%0d data=%0d done=%0b",
                     cyc, bus.upd_idx, bus.upd_data, bus.clr_done, e.cyc, e.idx, e.data, e.done);
          end
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          tests++;
          fails++;
          $display("FAIL missing_write: got none at cycle %0d, want idx=%0d data=%0d",
                   cyc, sbq[0].idx, sbq[0].data);
          void'(sbq.pop_front());
        end
        if (bus.clr_done) begin
          tests++;
          fails++;
          $display("FAIL clr_done_alone: got 1, want 0 (cycle %0d)", cyc);
        end
      end
    end
  end

  // One stimulus cycle: drive, check readies/busy/drop against the model,
  // then advance the model and push expected writes.
  task automatic step(input bit hv, input int hi, input int hd,
                      input bit av, input int ai, input int ad,
                      input bit cs, input int cv);
    int  c, win, idx, dat;
    bit  idle;
    @(posedge clock);
    #1;
    bus.host_valid = hv;  bus.host_idx = IDX_W'(hi);  bus.host_data = 2'(hd);
    bus.adp_valid  = av;  bus.adp_idx  = IDX_W'(ai);  bus.adp_data  = 2'(ad);
    bus.clr_start  = cs;  bus.clr_value = 2'(cv);
    #1;
    c    = cyc;
    idle = (c > busy_until);
    chk("busy", int'(bus.busy), int'(c >= busy_from && c <= busy_until));
    chk("drop_cnt", int'(bus.drop_cnt), exp_drop);
    win = 0;
    if (idle && !cs) begin
      if (hv && av) begin
        win = ptr_host ? 1 : 2;
        ptr_host = !ptr_host;
      end else if (hv) begin
        win = 1;
      end else if (av) begin
        win = 2;
      end
    end
    chk("host_ready", int'(bus.host_ready), int'(win == 1));
    chk("adp_ready", int'(bus.adp_ready), int'(win == 2));
    if (idle && cs) begin
      busy_from  = c + 1;
      busy_until = c + N;
      for (int i = 0; i < N; i++)
        sbq.push_back('{cyc: c + 1 + i, idx: i, data: cv % 4, done: (i == N - 1)});
    end else if (win != 0) begin
      idx = (win == 1) ? hi : ai;
      dat = (win == 1) ? hd : ad;
      if (idx >= N) exp_drop = (exp_drop < DROP_MAX) ? exp_drop + 1 : DROP_MAX;
      else sbq.push_back('{cyc: c + 1, idx: idx, data: dat % 4, done: 1'b0});
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    int rc;
    @(posedge clock);
    #1;
    bus.host_valid = 0; bus.adp_valid = 0; bus.clr_start = 0;
    reset = 1'b1;
    rc = cyc;
    while (sbq.size() > 0 && sbq[$].cyc > rc) void'(sbq.pop_back());
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_upd_valid", int'(bus.upd_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_upd_idx", int'(bus.upd_idx), 0);
    chk("rst_upd_data", int'(bus.upd_data), 0);
    chk("rst_clr_done", int'(bus.clr_done), 0);
    chk("rst_drop_cnt", int'(bus.drop_cnt), 0);
    ptr_host   = 1'b1;
    exp_drop   = 0;
    busy_from  = 1;
    busy_until = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bus.host_valid = 0; bus.host_idx = '0; bus.host_data = '0;
    bus.adp_valid  = 0; bus.adp_idx  = '0; bus.adp_data  = '0;
    bus.clr_start  = 0; bus.clr_value = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    do_reset();
    mon_en = 1'b1;

    // host-only write
    step(1, 5, 3, 0, 0, 0, 0, 0);
    idle_steps(2);

    // two-way contention alternates host, adp, host, adp
    for (int i = 0; i < 4; i++) step(1, 1, 2, 1, 2, 1, 0, 0);
    idle_steps(2);

    // out-of-range drops, saturating
    for (int i = 0; i < 300; i++) step(0, 0, 0, 1, N, 2, 0, 0);
    idle_steps(1);
    chk("drop_saturated", int'(bus.drop_cnt), DROP_MAX);

    // bulk clear with a pending host request and an ignored re-start
    step(1, 7, 2, 0, 0, 0, 1, 1);
    for (int i = 0; i < N; i++) step(1, 7, 2, 0, 0, 0, (i == 300), 2);
    step(1, 7, 2, 0, 0, 0, 0, 0);
    idle_steps(2);

    // reset in the middle of a sweep, then a fresh full sweep
    step(0, 0, 0, 0, 0, 0, 1, 2);
    idle_steps(500);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 3);
    idle_steps(N + 2);

    // randomized traffic with occasional clears
    for (int i = 0; i < 3000; i++) begin
      s = $urandom_range(0, 299);
      step($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 3),
           (s == 0), $urandom_range(0, 3));
    end
    while (cyc <= busy_until) idle_steps(1);
    idle_steps(3);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
